// File: rtl/secded_pkg.sv
// secded_pkg: shared SECDED helpers for the fault-tolerant counter.
//   chk_width(w)   number of Hamming check bits for a w-bit data word
//   data_pos(j)    1-based codeword position of data bit j
//   encode(d, w)   {overall parity, Hamming bits} for the low w bits of d.
//                  The result is sized for the widest supported word.
//                  Callers keep the low chk_width(w) Hamming bits and the
//                  parity bit at MAX_CHK.
package secded_pkg;

    localparam int MAX_W   = 64;
    localparam int MAX_CHK = 7;
    localparam int MAX_N   = MAX_W + MAX_CHK;

    typedef logic [MAX_CHK-1:0] syndrome_t;
    typedef enum logic [1:0] {CLEAN, SEC, DED} ecc_status_e;

    function automatic int chk_width(input int w);
        int r;
        r = MAX_CHK;
        // Walk downward so the smallest r that satisfies the rule is kept.
        for (int i = MAX_CHK; i >= 1; i--)
            if ((1 << i) >= w + i + 1) r = i;
        return r;
    endfunction

    function automatic bit is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    // Data bits fill the codeword positions that are not powers of two,
    // in ascending order.
    function automatic int data_pos(input int j);
        int k;
        int res;
        k   = 0;
        res = 0;
        for (int p = 1; p <= MAX_N; p++) begin
            if (!is_pow2(p)) begin
                if (k == j) res = p;
                k++;
            end
        end
        return res;
    endfunction

    function automatic logic [MAX_CHK:0] encode(input logic [MAX_W-1:0] data, input int w);
        logic [MAX_CHK:0] c;
        logic             par;
        int               j;
        c   = '0;
        par = 1'b0;
        j   = 0;
        for (int p = 1; p <= MAX_N; p++) begin
            if (!is_pow2(p) && j < w) begin
                if (data[j]) c[MAX_CHK-1:0] = c[MAX_CHK-1:0] ^ p[MAX_CHK-1:0];
                par = par ^ data[j];
                j++;
            end
        end
        c[MAX_CHK] = par ^ (^c[MAX_CHK-1:0]);
        return c;
    endfunction

endpackage

// File: rtl/secded_codec.sv
// secded_codec: combinational decoder for one stored SECDED word.
//   data       in   WIDTH     stored data bits
//   check      in   CHK_W+1   stored Hamming bits, overall parity at CHK_W
//   corrected  out  WIDTH     data with any single-bit data error flipped back
//   status     out  2         CLEAN / SEC (correctable) / DED (uncorrectable)
module secded_codec
    import secded_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHK_W = chk_width(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [CHK_W:0]   check,
    output logic [WIDTH-1:0] corrected,
    output ecc_status_e      status
);

    function automatic logic [CHK_W-1:0] hamming(input logic [WIDTH-1:0] d);
        logic [MAX_CHK:0] e;
        e = encode(MAX_W'(d), WIDTH);
        return e[CHK_W-1:0];
    endfunction

    syndrome_t s;
    logic      p;
    logic      in_range;

    always_comb begin
        s        = syndrome_t'(hamming(data) ^ check[CHK_W-1:0]);
        p        = ^{data, check};
        in_range = int'(s) <= WIDTH + CHK_W;

        // Odd parity with a syndrome pointing outside the codeword can only
        // come from three or more flips, so it is not trusted for correction.
        status = CLEAN;
        if (p && in_range)
            status = SEC;
        else if (p || s != '0)
            status = DED;

        corrected = data;
        if (status == SEC)
            for (int j = 0; j < WIDTH; j++)
                if (int'(s) == data_pos(j)) corrected[j] = ~data[j];
    end

endmodule

// File: rtl/secded_counter.sv
// secded_counter: up/down counter whose state lives in a SECDED codeword.
//   clk, reset      clock; asynchronous active-low reset
//   enable/up_down  count one step per cycle, 1 = up, 0 = down
//   load/load_val   synchronous load, wins over everything else
//   clr_status      clears sticky flags and err_cnt
//   counter         corrected count (combinational from storage)
//   wrap            registered one-cycle pulse after a wrapping step
//   single_err      storage currently holds a correctable error
//   double_err      storage currently holds an uncorrectable error
//   sec_sticky      latched single_err
//   ded_sticky      latched double_err
//   err_cnt         saturating count of cycles with single_err
module secded_counter
    import secded_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                up_down,
    input  logic                load,
    input  logic [WIDTH-1:0]    load_val,
    input  logic                clr_status,
    output logic [WIDTH-1:0]    counter,
    output logic                wrap,
    output logic                single_err,
    output logic                double_err,
    output logic                sec_sticky,
    output logic                ded_sticky,
    output logic [ERRCNT_W-1:0] err_cnt
);

    localparam int CHK_W = chk_width(WIDTH);

    function automatic logic [CHK_W:0] enc_word(input logic [WIDTH-1:0] d);
        logic [MAX_CHK:0] e;
        e = encode(MAX_W'(d), WIDTH);
        return {e[MAX_CHK], e[CHK_W-1:0]};
    endfunction

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [CHK_W:0]   check_q;
    logic [CHK_W:0]   check_d;
    logic [WIDTH-1:0] corrected;
    logic             wrap_d;
    ecc_status_e      status;

    secded_codec #(
        .WIDTH(WIDTH),
        .CHK_W(CHK_W)
    ) u_codec (
        .data     (data_q),
        .check    (check_q),
        .corrected(corrected),
        .status   (status)
    );

    assign counter    = corrected;
    assign single_err = (status == SEC);
    assign double_err = (status == DED);

    // Every write path re-encodes from corrected data, so a count step
    // also scrubs a single error and never propagates the bad bit.
    always_comb begin
        data_d  = data_q;
        check_d = check_q;
        wrap_d  = 1'b0;
        if (load) begin
            data_d  = load_val;
            check_d = enc_word(load_val);
        end else if (!double_err) begin
            if (enable) begin
                if (up_down) begin
                    data_d = corrected + WIDTH'(1);
                    wrap_d = &corrected;
                end else begin
                    data_d = corrected - WIDTH'(1);
                    wrap_d = ~|corrected;
                end
                check_d = enc_word(data_d);
            end else if (single_err) begin
                data_d  = corrected;
                check_d = enc_word(corrected);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q     <= '0;
            check_q    <= enc_word('0);
            wrap       <= 1'b0;
            sec_sticky <= 1'b0;
            ded_sticky <= 1'b0;
            err_cnt    <= '0;
        end else begin
            data_q  <= data_d;
            check_q <= check_d;
            wrap    <= wrap_d;
            if (clr_status) begin
                sec_sticky <= 1'b0;
                ded_sticky <= 1'b0;
                err_cnt    <= '0;
            end else begin
                if (single_err) sec_sticky <= 1'b1;
                if (double_err) ded_sticky <= 1'b1;
                if (single_err && !(&err_cnt)) err_cnt <= err_cnt + ERRCNT_W'(1);
            end
        end
    end

endmodule
